// File: rtl/fan_ctrl_pkg.sv
// Shared types for the thermostatic fan controller: state encoding and a
// helper that tells whether a state has the fan spinning.
package fan_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_OFF   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ON    = 2'd2,
        ST_BOOST = 2'd3
    } fan_state_t;

    function automatic logic is_running(input fan_state_t s);
        return (s == ST_ON) || (s == ST_BOOST);
    endfunction

endpackage

// File: rtl/fan_pwm_gen.sv
// Free-running PWM counter and registered fan drive: solid high in BOOST,
// DUTY_ON high cycles per period in ON, low otherwise.
module fan_pwm_gen #(
    parameter int PWM_W   = 8,
    parameter int DUTY_ON = 128
) (
    input  logic clk,
    input  logic rst,
    input  logic on,
    input  logic boost,
    output logic fan_pwm
);

    if (!(DUTY_ON >= 1 && DUTY_ON < (1 << PWM_W))) begin : g_bad_duty
        $error("fan_pwm_gen: DUTY_ON must satisfy 1 <= DUTY_ON < 2**PWM_W");
    end

    localparam logic [PWM_W-1:0] DUTY = PWM_W'(DUTY_ON);

    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
            fan_pwm <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            fan_pwm <= boost | (on & (pwm_cnt < DUTY));
        end
    end

endmodule

// File: rtl/fan_pwm_controller.sv
// Four-level thermostatic fan FSM with hysteresis; downward moves out of
// ON/BOOST wait for a minimum-dwell counter, upward moves never wait.
module fan_pwm_controller
    import fan_ctrl_pkg::*;
#(
    parameter int TEMP_W    = 8,
    parameter int T_OFF     = 24,
    parameter int T_ON      = 26,
    parameter int T_BOOST   = 30,
    parameter int PWM_W     = 8,
    parameter int DUTY_ON   = 128,
    parameter int DWELL_W   = 16,
    parameter int MIN_DWELL = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TEMP_W-1:0] temp,
    input  logic              temp_valid,
    output logic              fan_enable,
    output logic              fan_pwm,
    output logic [1:0]        fan_state,
    output logic              dwell_busy
);

    if (!(T_OFF < T_ON && T_ON <= T_BOOST)) begin : g_bad_thresholds
        $error("fan_pwm_controller: thresholds must satisfy T_OFF < T_ON <= T_BOOST");
    end
    if (!(MIN_DWELL >= 1 && MIN_DWELL <= (1 << DWELL_W))) begin : g_bad_dwell
        $error("fan_pwm_controller: MIN_DWELL must satisfy 1 <= MIN_DWELL <= 2**DWELL_W");
    end

    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(MIN_DWELL - 1);
    localparam logic [TEMP_W-1:0]  LVL_OFF    = TEMP_W'(T_OFF);
    localparam logic [TEMP_W-1:0]  LVL_ON     = TEMP_W'(T_ON);
    localparam logic [TEMP_W-1:0]  LVL_BOOST  = TEMP_W'(T_BOOST);

    fan_state_t         state, state_next, target;
    logic [DWELL_W-1:0] dwell_cnt, dwell_next;
    logic               pwm_on, pwm_boost;

    always_comb begin
        target = ST_OFF;
        if (temp >= LVL_BOOST)    target = ST_BOOST;
        else if (temp >= LVL_ON)  target = ST_ON;
        else if (temp >= LVL_OFF) target = ST_WAIT;
    end

    // A blocked downward request is simply dropped; the next sample decides anew.
    always_comb begin
        state_next = state;
        if (temp_valid) begin
            if (!is_running(state))
                state_next = target;
            else if (target > state)
                state_next = target;
            else if (target < state && !dwell_busy)
                state_next = target;
        end
    end

    // Reload on every entry into a running state, including BOOST -> ON.
    always_comb begin
        dwell_next = '0;
        if (is_running(state_next)) begin
            if (state_next != state)
                dwell_next = DWELL_LOAD;
            else if (dwell_cnt != '0)
                dwell_next = dwell_cnt - DWELL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_OFF;
            dwell_cnt <= '0;
        end else begin
            state     <= state_next;
            dwell_cnt <= dwell_next;
        end
    end

    assign fan_state  = state;
    assign fan_enable = is_running(state);
    assign dwell_busy = is_running(state) && (dwell_cnt != '0);
    assign pwm_on     = (state == ST_ON);
    assign pwm_boost  = (state == ST_BOOST);

    fan_pwm_gen #(
        .PWM_W   (PWM_W),
        .DUTY_ON (DUTY_ON)
    ) u_pwm_gen (
        .clk     (clk),
        .rst     (rst),
        .on      (pwm_on),
        .boost   (pwm_boost),
        .fan_pwm (fan_pwm)
    );

endmodule

// File: tb/tb_fan_pwm_controller.sv
// Directed bench for fan_pwm_controller: three instances share stimulus
// (MIN_DWELL=8 default PWM, MIN_DWELL=8 with a 4-bit PWM, MIN_DWELL=1).
module tb_fan_pwm_controller;

    logic       clk;
    logic       rst;
    logic [7:0] temp;
    logic       temp_valid;

    logic       a_en, a_pwm, a_busy;
    logic [1:0] a_state;
    logic       p_en, p_pwm, p_busy;
    logic [1:0] p_state;
    logic       m_en, m_pwm, m_busy;
    logic [1:0] m_state;

    int n_checks = 0;
    int n_fail   = 0;

    fan_pwm_controller #(.MIN_DWELL(8)) dut_a (
        .clk(clk), .rst(rst), .temp(temp), .temp_valid(temp_valid),
        .fan_enable(a_en), .fan_pwm(a_pwm), .fan_state(a_state), .dwell_busy(a_busy)
    );

    fan_pwm_controller #(.PWM_W(4), .DUTY_ON(5), .MIN_DWELL(8)) dut_p (
        .clk(clk), .rst(rst), .temp(temp), .temp_valid(temp_valid),
        .fan_enable(p_en), .fan_pwm(p_pwm), .fan_state(p_state), .dwell_busy(p_busy)
    );

    fan_pwm_controller #(.MIN_DWELL(1)) dut_m (
        .clk(clk), .rst(rst), .temp(temp), .temp_valid(temp_valid),
        .fan_enable(m_en), .fan_pwm(m_pwm), .fan_state(m_state), .dwell_busy(m_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample(input logic [7:0] t);
        temp       = t;
        temp_valid = 1'b1;
        step(1);
        temp_valid = 1'b0;
    endtask

    task automatic do_reset();
        temp_valid = 1'b0;
        rst        = 1'b1;
        step(1);
        rst        = 1'b0;
    endtask

    task automatic test_reset();
        temp_valid = 1'b0;
        rst = 1'b1;
        step(2);
        n_checks++; if (a_state !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_state: got %0d expected 0", a_state); end
        n_checks++; if (a_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_enable: got %b expected 0", a_en); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", a_busy); end
        n_checks++; if (a_pwm !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pwm: got %b expected 0", a_pwm); end
        rst = 1'b0;
        sample(8'd31);
        n_checks++; if (a_state !== 2'd3) begin n_fail++; $display("[TB] FAIL boost_entry_state: got %0d expected 3", a_state); end
        step(1);
        n_checks++; if (a_pwm !== 1'b1) begin n_fail++; $display("[TB] FAIL boost_pwm: got %b expected 1", a_pwm); end
        n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL boost_busy: got %b expected 1", a_busy); end
        rst = 1'b1;
        temp = 8'd40;
        temp_valid = 1'b1;
        step(1);
        temp_valid = 1'b0;
        n_checks++; if (a_state !== 2'd0) begin n_fail++; $display("[TB] FAIL midreset_state: got %0d expected 0", a_state); end
        n_checks++; if (a_en !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_enable: got %b expected 0", a_en); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_busy: got %b expected 0", a_busy); end
        rst = 1'b0;
        step(1);
        n_checks++; if (a_pwm !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_pwm: got %b expected 0", a_pwm); end
        n_checks++; if (a_state !== 2'd0) begin n_fail++; $display("[TB] FAIL midreset_hold: got %0d expected 0", a_state); end
    endtask

    task automatic test_ladder();
        do_reset();
        sample(8'd24);
        n_checks++; if (a_state !== 2'd1) begin n_fail++; $display("[TB] FAIL ladder_24_state: got %0d expected 1", a_state); end
        n_checks++; if (a_en !== 1'b0) begin n_fail++; $display("[TB] FAIL ladder_24_enable: got %b expected 0", a_en); end
        sample(8'd26);
        n_checks++; if (a_state !== 2'd2) begin n_fail++; $display("[TB] FAIL ladder_26_state: got %0d expected 2", a_state); end
        n_checks++; if (a_en !== 1'b1) begin n_fail++; $display("[TB] FAIL ladder_26_enable: got %b expected 1", a_en); end
        sample(8'd30);
        n_checks++; if (a_state !== 2'd3) begin n_fail++; $display("[TB] FAIL ladder_30_state: got %0d expected 3", a_state); end
        n_checks++; if (a_en !== 1'b1) begin n_fail++; $display("[TB] FAIL ladder_30_enable: got %b expected 1", a_en); end
        sample(8'd23);
        n_checks++; if (a_state !== 2'd3) begin n_fail++; $display("[TB] FAIL ladder_drop_gated: got %0d expected 3", a_state); end
    endtask

    // ON entered at edge e; samples land on edges e+3 (blocked) and e+8 (allowed).
    task automatic test_dwell();
        do_reset();
        sample(8'd26);
        n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL dwell_entry_busy: got %b expected 1", a_busy); end
        step(2);
        sample(8'd20);
        n_checks++; if (a_state !== 2'd2) begin n_fail++; $display("[TB] FAIL dwell_blocked_state: got %0d expected 2", a_state); end
        n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL dwell_blocked_busy: got %b expected 1", a_busy); end
        step(3);
        n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL dwell_e6_busy: got %b expected 1", a_busy); end
        step(1);
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL dwell_e7_busy: got %b expected 0", a_busy); end
        n_checks++; if (a_state !== 2'd2) begin n_fail++; $display("[TB] FAIL dwell_no_memory: got %0d expected 2", a_state); end
        sample(8'd20);
        n_checks++; if (a_state !== 2'd0) begin n_fail++; $display("[TB] FAIL dwell_release_state: got %0d expected 0", a_state); end
        n_checks++; if (a_en !== 1'b0) begin n_fail++; $display("[TB] FAIL dwell_release_enable: got %b expected 0", a_en); end
    endtask

    task automatic test_upward();
        do_reset();
        sample(8'd26);
        step(2);
        sample(8'd31);
        n_checks++; if (a_state !== 2'd3) begin n_fail++; $display("[TB] FAIL upward_state: got %0d expected 3", a_state); end
        step(6);
        n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL reload_f6_busy: got %b expected 1", a_busy); end
        step(1);
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reload_f7_busy: got %b expected 0", a_busy); end
        sample(8'd27);
        n_checks++; if (a_state !== 2'd2) begin n_fail++; $display("[TB] FAIL boost_to_on_state: got %0d expected 2", a_state); end
        n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL boost_to_on_busy: got %b expected 1", a_busy); end
        sample(8'd20);
        n_checks++; if (a_state !== 2'd2) begin n_fail++; $display("[TB] FAIL boost_to_on_gated: got %0d expected 2", a_state); end
    endtask

    task automatic test_pwm();
        int hi;
        int hi_a;
        do_reset();
        sample(8'd26);
        step(1);
        hi = 0;
        for (int i = 0; i < 32; i++) begin
            hi += int'(p_pwm);
            step(1);
        end
        n_checks++; if (hi !== 10) begin n_fail++; $display("[TB] FAIL pwm_on_duty4: got %0d high expected 10", hi); end
        hi_a = 0;
        for (int i = 0; i < 256; i++) begin
            hi_a += int'(a_pwm);
            step(1);
        end
        n_checks++; if (hi_a !== 128) begin n_fail++; $display("[TB] FAIL pwm_on_duty8: got %0d high expected 128", hi_a); end
        sample(8'd31);
        step(1);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            hi += int'(p_pwm);
            step(1);
        end
        n_checks++; if (hi !== 16) begin n_fail++; $display("[TB] FAIL pwm_boost: got %0d high expected 16", hi); end
        do_reset();
        sample(8'd24);
        step(1);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            hi += int'(p_pwm) + int'(a_pwm);
            step(1);
        end
        n_checks++; if (hi !== 0) begin n_fail++; $display("[TB] FAIL pwm_wait: got %0d high expected 0", hi); end
        n_checks++; if (a_state !== 2'd1) begin n_fail++; $display("[TB] FAIL pwm_wait_state: got %0d expected 1", a_state); end
    endtask

    task automatic test_no_valid();
        int moved;
        do_reset();
        temp       = 8'd40;
        temp_valid = 1'b0;
        moved = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (a_state !== 2'd0 || m_state !== 2'd0 || a_en !== 1'b0) moved++;
        end
        n_checks++; if (moved !== 0) begin n_fail++; $display("[TB] FAIL novalid_hold: got %0d moved cycles expected 0", moved); end
        sample(8'd40);
        n_checks++; if (a_state !== 2'd3) begin n_fail++; $display("[TB] FAIL novalid_then_valid: got %0d expected 3", a_state); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        sample(8'd26);
        n_checks++; if (m_state !== 2'd2) begin n_fail++; $display("[TB] FAIL md1_entry_state: got %0d expected 2", m_state); end
        n_checks++; if (m_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL md1_entry_busy: got %b expected 0", m_busy); end
        sample(8'd20);
        n_checks++; if (m_state !== 2'd0) begin n_fail++; $display("[TB] FAIL md1_immediate_off: got %0d expected 0", m_state); end
        n_checks++; if (a_state !== 2'd2) begin n_fail++; $display("[TB] FAIL md8_gated_on: got %0d expected 2", a_state); end
        do_reset();
        sample(8'd26);
        sample(8'd30);
        n_checks++; if (a_state !== 2'd3) begin n_fail++; $display("[TB] FAIL b2b_off_on_boost: got %0d expected 3", a_state); end
    endtask

    initial begin
        rst        = 1'b1;
        temp       = 8'd0;
        temp_valid = 1'b0;
        test_reset();
        test_ladder();
        test_dwell();
        test_upward();
        test_pwm();
        test_no_valid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
